// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter in front of a shared 4:1 data mux.
// One requester holds the mux at a time. Its tenure ends when it drops its
// request or after MAX_HOLD accepted transfers, followed by one IDLE cycle
// in which the next winner is chosen, searching from the last grantee + 1.

module rr_mux_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic             ready,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] y,
    output logic             valid,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic [3:0]       hold_cnt_q, hold_cnt_d;

    logic             found;
    logic [1:0]       winner;
    logic [1:0]       idx;
    logic             xfer;
    logic [WIDTH-1:0] mux_out;

    // Rotating priority search: last+1, last+2, last+3, then last itself.
    always_comb begin
        found  = 1'b0;
        winner = last_q;
        idx    = last_q;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Combinational 4:1 data mux driven by the registered select.
    always_comb begin
        mux_out = '0;
        case (sel_q)
            2'd0:    mux_out = d0;
            2'd1:    mux_out = d1;
            2'd2:    mux_out = d2;
            default: mux_out = d3;
        endcase
    end

    assign busy  = (state_q == GRANT);
    assign valid = busy && req[sel_q];
    assign y     = busy ? mux_out : '0;
    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign xfer  = valid && ready;

    // Next-state logic: arbitrate in IDLE, count transfers and release in GRANT.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                gnt_d = 4'b0000;
                if (found) begin
                    gnt_d      = 4'b0001 << winner;
                    sel_d      = winner;
                    hold_cnt_d = 4'd0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (!req[sel_q] || (xfer && hold_cnt_q == HOLD_LAST)) begin
                    last_d     = sel_q;
                    gnt_d      = 4'b0000;
                    hold_cnt_d = 4'd0;
                    state_d    = IDLE;
                end else if (xfer) begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                gnt_d      = 4'b0000;
                hold_cnt_d = 4'd0;
            end
        endcase
    end

    // State registers; last resets to 3 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= 4'b0000;
            sel_q      <= 2'd0;
            last_q     <= 2'd3;
            hold_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

endmodule
